// File: rtl/mem_access_pkg.sv
// mem_access_pkg
//    Shared definitions for the load/store unit: datapath width, default
//    memory depth, access-size encodings and the FSM state encoding.
package mem_access_pkg;

   localparam int DATA_W        = 32;
   localparam int MEM_WORDS_DEF = 128;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_ILL  = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RD   = 2'b01,
      WR   = 2'b10,
      RESP = 2'b11
   } state_e;

endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if
//    Bundles the CPU-side request/response handshake and the word-addressed
//    data-memory port of mem_access_unit.
//    slave  : view of the load/store unit (takes requests, drives memory)
//    master : view of the environment (issues requests, models memory)
interface mem_access_unit_if;
   import mem_access_pkg::*;

   // request / response
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [1:0]        req_size;
   logic              req_signed;
   logic [DATA_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              resp_valid;
   logic [DATA_W-1:0] resp_rdata;
   logic              resp_err;

   // data memory
   logic [DATA_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_write;
   logic              mem_read;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
      input  mem_rdata,
      output req_ready, resp_valid, resp_rdata, resp_err,
      output mem_addr, mem_wdata, mem_write, mem_read
   );

   modport master (
      output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
      output mem_rdata,
      input  req_ready, resp_valid, resp_rdata, resp_err,
      input  mem_addr, mem_wdata, mem_write, mem_read
   );

endinterface

// File: rtl/mem_lane_align.sv
// mem_lane_align
//    Purely combinational little-endian lane handling.
//    byte_off : byte offset within the word (addr[1:0])
//    size     : access size encoding (SZ_BYTE/SZ_HALF/SZ_WORD)
//    sign_ext : sign-extend sub-word loads when set
//    ld_word  : memory word being loaded        -> ld_data : extracted, extended value
//    st_base  : current memory word (read back)  -> st_word : word with lane replaced
//    st_data  : right-aligned store data
module mem_lane_align
   import mem_access_pkg::*;
(
   input  logic [1:0]        byte_off,
   input  logic [1:0]        size,
   input  logic              sign_ext,
   input  logic [DATA_W-1:0] ld_word,
   output logic [DATA_W-1:0] ld_data,
   input  logic [DATA_W-1:0] st_base,
   input  logic [DATA_W-1:0] st_data,
   output logic [DATA_W-1:0] st_word
);

   logic [4:0]  byte_lsb;
   logic [4:0]  half_lsb;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   always_comb begin
      byte_lsb = {byte_off, 3'b000};
      half_lsb = {byte_off[1], 4'b0000};
      ld_byte  = ld_word[byte_lsb +: 8];
      ld_half  = ld_word[half_lsb +: 16];

      ld_data = ld_word;
      st_word = st_data;
      case (size)
         SZ_BYTE: begin
            ld_data = sign_ext ? {{24{ld_byte[7]}}, ld_byte} : {24'h0, ld_byte};
            st_word = st_base;
            st_word[byte_lsb +: 8] = st_data[7:0];
         end
         SZ_HALF: begin
            ld_data = sign_ext ? {{16{ld_half[15]}}, ld_half} : {16'h0, ld_half};
            st_word = st_base;
            st_word[half_lsb +: 16] = st_data[15:0];
         end
         default: begin
            // full word: no extension, store replaces the whole word
            ld_data = ld_word;
            st_word = st_data;
         end
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit
//    Load/store initiator between the CPU and a word-addressed data memory.
//    Byte addresses are turned into word-indexed read/write cycles; sub-word
//    stores are done as read-modify-write.
//    clk, rst : clock and asynchronous active-high reset
//    bus      : request/response handshake plus memory port (slave view)
module mem_access_unit
   import mem_access_pkg::*;
#(
   parameter int MEM_WORDS = MEM_WORDS_DEF
) (
   input  logic             clk,
   input  logic             rst,
   mem_access_unit_if.slave bus
);

   state_e            state_q, state_d;
   logic [DATA_W-1:0] addr_q, addr_d;
   logic [1:0]        size_q, size_d;
   logic              signed_q, signed_d;
   logic              write_q, write_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdbuf_q, rdbuf_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;

   logic              req_err;
   logic [DATA_W-1:0] ld_data;
   logic [DATA_W-1:0] st_word;

   mem_lane_align u_align (
      .byte_off (addr_q[1:0]),
      .size     (size_q),
      .sign_ext (signed_q),
      .ld_word  (bus.mem_rdata),
      .ld_data  (ld_data),
      .st_base  (rdbuf_q),
      .st_data  (wdata_q),
      .st_word  (st_word)
   );

   // Error conditions evaluated on the incoming request at accept time.
   always_comb begin
      req_err = (bus.req_size == SZ_ILL)
             || ((bus.req_size == SZ_HALF) && bus.req_addr[0])
             || ((bus.req_size == SZ_WORD) && (bus.req_addr[1:0] != 2'b00))
             || ({2'b00, bus.req_addr[31:2]} >= 32'(MEM_WORDS));
   end

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      size_d   = size_q;
      signed_d = signed_q;
      write_d  = write_q;
      wdata_d  = wdata_q;
      rdbuf_d  = rdbuf_q;
      rdata_d  = rdata_q;
      err_d    = err_q;

      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               addr_d   = bus.req_addr;
               size_d   = bus.req_size;
               signed_d = bus.req_signed;
               write_d  = bus.req_write;
               wdata_d  = bus.req_wdata;
               err_d    = req_err;
               rdata_d  = '0;          // stores and errors return zero
               if (req_err)
                  state_d = RESP;
               else if (!bus.req_write)
                  state_d = RD;
               else if (bus.req_size == SZ_WORD)
                  state_d = WR;        // full word needs no read-back
               else
                  state_d = RD;        // sub-word store: read-modify-write
            end
         end
         RD: begin
            rdbuf_d = bus.mem_rdata;
            if (write_q) begin
               state_d = WR;
            end else begin
               rdata_d = ld_data;
               state_d = RESP;
            end
         end
         WR:      state_d = RESP;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         size_q   <= '0;
         signed_q <= 1'b0;
         write_q  <= 1'b0;
         wdata_q  <= '0;
         rdbuf_q  <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         size_q   <= size_d;
         signed_q <= signed_d;
         write_q  <= write_d;
         wdata_q  <= wdata_d;
         rdbuf_q  <= rdbuf_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      bus.req_ready  = (state_q == IDLE) && !rst;
      bus.resp_valid = (state_q == RESP);
      bus.resp_err   = err_q;
      bus.resp_rdata = rdata_q;
      bus.mem_read   = (state_q == RD);
      // Gated by rst so an asserted reset never lets a write edge through.
      bus.mem_write  = (state_q == WR) && !rst;
      bus.mem_addr   = ((state_q == RD) || (state_q == WR)) ? {2'b00, addr_q[31:2]} : '0;
      bus.mem_wdata  = (state_q == WR) ? st_word : '0;
   end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
   import mem_access_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic preload = 1'b1;
   always #5 clk = ~clk;

   mem_access_unit_if bus();

   mem_access_unit #(.MEM_WORDS(128)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ---------------- memory model (128 words) ----------------
   logic [31:0] tmem     [128];
   logic [31:0] init_mem [128];
   logic [7:0]  smem     [512];   // byte-level shadow of expected contents

   assign bus.mem_rdata = (bus.mem_addr < 32'd128) ? tmem[bus.mem_addr[6:0]] : 32'h0;

   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 128; i++) tmem[i] <= init_mem[i];
      end else if (bus.mem_write && (bus.mem_addr < 32'd128)) begin
         tmem[bus.mem_addr[6:0]] <= bus.mem_wdata;
      end
   end

   int n_vec = 0;
   int n_checks = 0;
   int miscompares = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // ---------------- behavioural reference ----------------
   function automatic int nbytes(input logic [1:0] sz);
      return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
   endfunction

   function automatic logic model_err(input logic [1:0] sz, input logic [31:0] a);
      int n = nbytes(sz);
      return (sz == 2'b11) || ((a % 32'(n)) != 0) || (a >= 32'd512);
   endfunction

   function automatic logic [31:0] shadow_word(input int idx);
      return {smem[4*idx+3], smem[4*idx+2], smem[4*idx+1], smem[4*idx]};
   endfunction

   function automatic logic [31:0] model_load(input logic [1:0] sz, input logic sg, input logic [31:0] a);
      logic [31:0] v = 32'h0;
      int n = nbytes(sz);
      for (int i = 0; i < n; i++) v[8*i +: 8] = smem[int'(a) + i];
      if (sg && n < 4 && v[8*n-1])
         for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
      return v;
   endfunction

   task automatic model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
      int n = nbytes(sz);
      for (int i = 0; i < n; i++) smem[int'(a) + i] = wd[8*i +: 8];
   endtask

   // ---------------- driver / monitor ----------------
   task automatic run_req(input logic w, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd,
                          output int lat, output int nrd, output int nwr,
                          output logic err, output logic [31:0] rd,
                          output logic [31:0] maddr, output logic [31:0] mwdata);
      int c;
      lat = -1; nrd = 0; nwr = 0; err = 1'b0; rd = 32'h0; maddr = 32'h0; mwdata = 32'h0;
      c = 0;
      while (!bus.req_ready && c < 10) begin
         @(negedge clk);
         c++;
      end
      bus.req_write  = w;
      bus.req_size   = sz;
      bus.req_signed = sg;
      bus.req_addr   = a;
      bus.req_wdata  = wd;
      bus.req_valid  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      // request fields must be ignored once accepted
      bus.req_valid = 1'b0;
      bus.req_addr  = $urandom;
      bus.req_wdata = $urandom;
      bus.req_size  = 2'($urandom_range(0, 3));
      for (int k = 1; k <= 8; k++) begin
         if (k > 1) @(negedge clk);
         if (bus.mem_read) begin
            nrd++;
            maddr = bus.mem_addr;
         end
         if (bus.mem_write) begin
            nwr++;
            maddr  = bus.mem_addr;
            mwdata = bus.mem_wdata;
         end
         if (bus.resp_valid) begin
            lat = k;
            err = bus.resp_err;
            rd  = bus.resp_rdata;
            break;
         end
      end
   endtask

   task automatic check_txn(input string tag, input logic w, input logic [1:0] sz, input logic sg,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic e_err, input logic [31:0] e_rd, input int e_lat,
                            input int e_nrd, input int e_nwr,
                            input logic [31:0] e_maddr, input logic [31:0] e_wdata);
      int lat, nrd, nwr;
      logic err;
      logic [31:0] rd, maddr, mwdata;
      int f0 = miscompares;
      run_req(w, sz, sg, a, wd, lat, nrd, nwr, err, rd, maddr, mwdata);
      n_vec++;
      chk({tag, " resp_err"}, {31'h0, err}, {31'h0, e_err});
      chk({tag, " resp_rdata"}, rd, e_rd);
      chk({tag, " latency"}, 32'(lat), 32'(e_lat));
      chk({tag, " mem_read cycles"}, 32'(nrd), 32'(e_nrd));
      chk({tag, " mem_write cycles"}, 32'(nwr), 32'(e_nwr));
      if (e_nrd + e_nwr > 0) chk({tag, " mem_addr"}, maddr, e_maddr);
      if (e_nwr > 0) chk({tag, " mem_wdata"}, mwdata, e_wdata);
      if (a < 32'd512) chk({tag, " memory word"}, tmem[a[8:2]], shadow_word(int'(a[8:2])));
      $display("txn %0d %s w=%0d sz=%0d sg=%0d addr=0x%08h wd=0x%08h -> err=%0d rd=0x%08h lat=%0d %s",
               n_vec, tag, w, sz, sg, a, wd, err, rd, lat, (miscompares == f0) ? "ok" : "bad");
   endtask

   typedef struct {
      logic        w;
      logic [1:0]  sz;
      logic        sg;
      logic [31:0] a;
      logic [31:0] wd;
      logic        e_err;
      logic [31:0] e_rd;
      int          e_lat;
      int          e_nrd;
      int          e_nwr;
      logic [31:0] e_maddr;
      logic [31:0] e_wdata;
   } vec_t;

   vec_t tbl[10];

   initial begin
      logic w, sg, e_err;
      logic [1:0] sz;
      logic [31:0] a, wd, e_rd, e_wdata;
      int n, e_lat, e_nrd, e_nwr;

      bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
      bus.req_signed = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;

      for (int i = 0; i < 128; i++) init_mem[i] = $urandom;
      init_mem[4] = 32'h8899AABB;
      for (int i = 0; i < 128; i++)
         for (int b = 0; b < 4; b++) smem[4*i+b] = init_mem[i][8*b +: 8];

      //            w     sz     sg    addr          wdata         err   rdata         lat rd wr maddr  wdata
      tbl[0] = '{1'b0, 2'b00, 1'b1, 32'h0000_0011, 32'h0,        1'b0, 32'hFFFFFFAA, 2, 1, 0, 32'd4, 32'h0};
      tbl[1] = '{1'b0, 2'b01, 1'b0, 32'h0000_0012, 32'h0,        1'b0, 32'h00008899, 2, 1, 0, 32'd4, 32'h0};
      tbl[2] = '{1'b0, 2'b01, 1'b1, 32'h0000_0012, 32'h0,        1'b0, 32'hFFFF8899, 2, 1, 0, 32'd4, 32'h0};
      tbl[3] = '{1'b1, 2'b00, 1'b0, 32'h0000_0013, 32'h5C,       1'b0, 32'h0,        3, 1, 1, 32'd4, 32'h5C99AABB};
      tbl[4] = '{1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,        1'b0, 32'h5C99AABB, 2, 1, 0, 32'd4, 32'h0};
      tbl[5] = '{1'b1, 2'b10, 1'b0, 32'h0000_0020, 32'hDEADBEEF, 1'b0, 32'h0,        2, 0, 1, 32'd8, 32'hDEADBEEF};
      tbl[6] = '{1'b0, 2'b00, 1'b1, 32'h0000_0023, 32'h0,        1'b0, 32'hFFFFFFDE, 2, 1, 0, 32'd8, 32'h0};
      tbl[7] = '{1'b0, 2'b01, 1'b0, 32'h0000_0011, 32'h0,        1'b1, 32'h0,        1, 0, 0, 32'd0, 32'h0};
      tbl[8] = '{1'b0, 2'b10, 1'b0, 32'h0000_0200, 32'h0,        1'b1, 32'h0,        1, 0, 0, 32'd0, 32'h0};
      tbl[9] = '{1'b0, 2'b11, 1'b0, 32'h0000_0000, 32'h0,        1'b1, 32'h0,        1, 0, 0, 32'd0, 32'h0};

      // reset state
      repeat (2) @(posedge clk);
      preload = 1'b0;
      @(negedge clk);
      chk("reset req_ready", {31'h0, bus.req_ready}, 32'h0);
      chk("reset resp_valid", {31'h0, bus.resp_valid}, 32'h0);
      chk("reset resp_err", {31'h0, bus.resp_err}, 32'h0);
      chk("reset resp_rdata", bus.resp_rdata, 32'h0);
      chk("reset mem_read", {31'h0, bus.mem_read}, 32'h0);
      chk("reset mem_write", {31'h0, bus.mem_write}, 32'h0);
      chk("reset mem_addr", bus.mem_addr, 32'h0);
      chk("reset mem_wdata", bus.mem_wdata, 32'h0);
      rst = 1'b0;
      #1;
      chk("ready after reset", {31'h0, bus.req_ready}, 32'h1);

      // directed table
      foreach (tbl[i]) begin
         if (tbl[i].w && !model_err(tbl[i].sz, tbl[i].a)) model_store(tbl[i].sz, tbl[i].a, tbl[i].wd);
         check_txn($sformatf("tbl%0d", i), tbl[i].w, tbl[i].sz, tbl[i].sg, tbl[i].a, tbl[i].wd,
                   tbl[i].e_err, tbl[i].e_rd, tbl[i].e_lat, tbl[i].e_nrd, tbl[i].e_nwr,
                   tbl[i].e_maddr, tbl[i].e_wdata);
      end

      // reset during the WR cycle of a byte store: memory must stay untouched
      begin
         int c = 0;
         while (!bus.req_ready && c < 10) begin
            @(negedge clk);
            c++;
         end
         bus.req_write = 1'b1; bus.req_size = 2'b00; bus.req_signed = 1'b0;
         bus.req_addr = 32'h11; bus.req_wdata = 32'h77; bus.req_valid = 1'b1;
         @(posedge clk);
         @(negedge clk);
         bus.req_valid = 1'b0;
         chk("rmw-abort RD mem_read", {31'h0, bus.mem_read}, 32'h1);
         @(negedge clk);
         chk("rmw-abort WR mem_write", {31'h0, bus.mem_write}, 32'h1);
         rst = 1'b1;
         #1;
         chk("rmw-abort mem_write dropped", {31'h0, bus.mem_write}, 32'h0);
         chk("rmw-abort mem_addr", bus.mem_addr, 32'h0);
         chk("rmw-abort mem_wdata", bus.mem_wdata, 32'h0);
         chk("rmw-abort mem_read", {31'h0, bus.mem_read}, 32'h0);
         chk("rmw-abort resp_valid", {31'h0, bus.resp_valid}, 32'h0);
         chk("rmw-abort resp_rdata", bus.resp_rdata, 32'h0);
         chk("rmw-abort req_ready", {31'h0, bus.req_ready}, 32'h0);
         @(posedge clk);
         @(negedge clk);
         chk("rmw-abort memory word", tmem[4], shadow_word(4));
         rst = 1'b0;
         #1;
         chk("rmw-abort ready after reset", {31'h0, bus.req_ready}, 32'h1);
         n_vec++;
         $display("txn %0d rst-during-WR addr=0x00000011 -> mem[4]=0x%08h", n_vec, tmem[4]);
      end

      // randomized traffic against the byte-level reference
      for (int t = 0; t < 300; t++) begin
         n = $urandom_range(0, 9);
         sz = (n < 3) ? 2'b00 : (n < 6) ? 2'b01 : (n < 9) ? 2'b10 : 2'b11;
         a = ($urandom_range(0, 15) == 0) ? 32'($urandom) : 32'($urandom_range(0, 511));
         if (sz != 2'b11 && $urandom_range(0, 3) != 0) a = a & ~(32'(nbytes(sz)) - 32'd1);
         w  = 1'($urandom_range(0, 1));
         sg = 1'($urandom_range(0, 1));
         wd = $urandom;
         e_err = model_err(sz, a);
         e_rd = 32'h0; e_wdata = 32'h0; e_nrd = 0; e_nwr = 0;
         if (e_err) begin
            e_lat = 1;
         end else if (!w) begin
            e_rd = model_load(sz, sg, a);
            e_lat = 2; e_nrd = 1;
         end else begin
            model_store(sz, a, wd);
            e_wdata = shadow_word(int'(a[8:2]));
            e_nwr = 1;
            e_nrd = (nbytes(sz) < 4) ? 1 : 0;
            e_lat = (nbytes(sz) < 4) ? 3 : 2;
         end
         check_txn("rand", w, sz, sg, a, wd, e_err, e_rd, e_lat, e_nrd, e_nwr, a >> 2, e_wdata);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, miscompares);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Load/store initiator between the CPU datapath and the word-addressed data memory (128 x 32-bit, combinational read, write on posedge clk).
- Accepts byte/half/word load and store requests using byte addresses.
- Translates each request into word-indexed memory read/write cycles. Sub-word stores use read-modify-write.
- Returns aligned, sign/zero-extended load data and an error flag through a valid/ready handshake.

Parameters:
DATA_W, 32, data width of datapath and memory word
MEM_WORDS, 128, number of words in data memory; word index >= MEM_WORDS is out of range

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
req_valid  in  1  request present
req_ready  out  1  unit can accept request (IDLE and rst low)
req_write  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
resp_valid  out  1  one-cycle pulse: request complete
resp_rdata  out  32  load result; 0 for stores and errors
resp_err  out  1  valid with resp_valid: misaligned, illegal size, or out of range
mem_addr  out  32  word index to memory (req_addr >> 2); 0 when idle
mem_wdata  out  32  write data to memory; 0 outside WR
mem_write  out  1  memory write enable
mem_read  out  1  memory read enable
mem_rdata  in  32  memory read data (combinational)

Behaviour:
- Reset (async, rst=1): state IDLE; resp_valid=0, resp_err=0, resp_rdata=0; mem_read, mem_write, mem_addr, mem_wdata all 0; req_ready=0.
  - mem_write is gated by ~rst combinationally, so no memory write occurs at any edge while rst is high.
  - Reset mid-RMW aborts the operation; the memory word is left unchanged.
- FSM states: IDLE, RD, WR, RESP.
- Accept: req_valid & req_ready at posedge. Latch addr, size, signed, write, wdata. Compute error at accept:
  - size==11
  - half with addr[0]!=0
  - word with addr[1:0]!=0
  - addr[31:2] >= MEM_WORDS
- Transitions out of IDLE on accept:
  - error -> RESP
  - load -> RD
  - word store -> WR
  - byte/half store -> RD
- RD: mem_read=1, mem_addr=word index. At the edge, capture mem_rdata into rdbuf. Next state is RESP for a load, WR for a store.
- WR: mem_write=1, mem_addr=word index, mem_wdata = merged word. Next state is RESP.
- RESP: resp_valid=1 for exactly one cycle, resp_err and resp_rdata held registered. Next state is IDLE. req_ready=0 in RESP, so back-to-back accept occurs in the cycle after RESP.
- Latency (accept edge = cycle 0):
  - load: RD in cycle 1, resp_valid in cycle 2
  - word store: WR in cycle 1, resp_valid in cycle 2
  - sub-word store: RD in cycle 1, WR in cycle 2, resp_valid in cycle 3
  - error: resp_valid in cycle 1
- Lanes are little-endian: byte lane k = bits[8k+7:8k], with k = addr[1:0]; half lane = addr[1].
- Load extract: select the lane and extend to 32 bits using req_signed. Word loads ignore req_signed.
- Store merge: replace the addressed lane with req_wdata low bits; other lanes come from rdbuf.
- Errors issue no mem_read or mem_write pulse.
- mem_rdata is sampled only at the end of RD.
- req_valid/request fields are ignored outside IDLE.

Decomposition:
- Package mem_access_pkg holds:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10
  - FSM state encoding
  - MEM_WORDS default
- One combinational sub-module, mem_lane_align, holds load extract (lane select + extension) and store merge (lane insert into rdbuf). The top keeps only the FSM, registers and error checks.

Test Plan:
(Memory preloaded: word 4 = 0x8899AABB.)
1. Signed byte load, addr 0x11 -> mem_read high exactly 1 cycle with mem_addr=4; resp_valid in cycle 2; resp_rdata=0xFFFFFFAA; resp_err=0.
2. Unsigned half load, addr 0x12 -> resp_rdata=0x00008899.
3. Byte store 0x5C, addr 0x13 -> RD (mem_read, mem_addr=4), then WR (mem_write 1 cycle, mem_wdata=0x5C99AABB); resp_valid in cycle 3. A following word load at 0x10 returns 0x5C99AABB.
4. Word store 0xDEADBEEF, addr 0x20 -> no mem_read; mem_write 1 cycle with mem_addr=8, mem_wdata=0xDEADBEEF; resp_valid in cycle 2; resp_rdata=0.
5. Half load at 0x11, word load at 0x200, and size=11 at 0x0 -> each gives resp_err=1, resp_rdata=0, resp_valid in cycle 1; mem_read and mem_write never asserted.
6. rst asserted during WR of a byte store -> mem_write drops immediately with no memory update; all outputs return to reset values; req_ready=1 in the first cycle after rst deasserts.
